// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and sizing helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

  // ALU control codes, identical to the decoder encoding
  localparam logic [4:0] OP_MULTU = 5'b00111;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Iteration counter must hold the value WIDTH itself
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Multiply: acc_hi holds the running upper product (bit WIDTH is the carry-free
// headroom), acc_lo holds the low product bits with the multiplier shifting out.
// Divide: acc_hi is the partial remainder, acc_lo the dividend shifting out while
// quotient bits shift in (qbit is merged into bit 0 by the caller).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             qbit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor;
  logic [WIDTH+1:0] diff;

  // Both candidate results are formed, mode selects which one is returned
  always_comb begin
    sum     = acc_hi + {1'b0, (acc_lo[0] ? opnd : '0)};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    divisor = (WIDTH+2)'(opnd);
    diff    = shifted - divisor;
    nxt_hi  = '0;
    nxt_lo  = '0;
    qbit    = 1'b0;
    if (is_div) begin
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      if (shifted >= divisor) begin
        qbit   = 1'b1;
        nxt_hi = (WIDTH+1)'(diff);
      end else begin
        nxt_hi = (WIDTH+1)'(shifted);
      end
    end else begin
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Operands are reduced to magnitudes at accept time; signs are re-applied in FIX.
// A zero divisor keeps the raw dividend and no sign flags, so the restoring loop
// naturally yields HI = a and LO = all ones.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH:0]   acc_hi, acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic             is_div, is_div_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic             dz, dz_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;

  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             step_qbit;

  logic             op_div, op_signed, op_md, b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo),
    .qbit   (step_qbit)
  );

  // Command decode and operand magnitude extraction
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_DIV) || (op == OP_MULT);
  assign op_md     = op_div || (op == OP_MULT) || (op == OP_MULTU);
  assign b_zero    = op_div && (b == '0);
  assign a_neg     = op_signed && a[WIDTH-1] && !b_zero;
  assign b_neg     = op_signed && b[WIDTH-1] && !b_zero;
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Sign correction applied while in FIX
  assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_hi_nxt   = acc_hi;
    acc_lo_nxt   = acc_lo;
    opnd_nxt     = opnd;
    is_div_nxt   = is_div;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    dz_nxt       = dz;
    hi_nxt       = hi;
    lo_nxt       = lo;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    div_zero_nxt = div_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_nxt = a;
          end else if (op == OP_MTLO) begin
            lo_nxt = a;
          end else if (op_md) begin
            acc_hi_nxt   = '0;
            acc_lo_nxt   = a_mag;
            opnd_nxt     = b_mag;
            is_div_nxt   = op_div;
            neg_q_nxt    = a_neg ^ b_neg;
            neg_r_nxt    = a_neg;
            dz_nxt       = b_zero;
            div_zero_nxt = 1'b0;
            cnt_nxt      = CW'(WIDTH);
            busy_nxt     = 1'b1;
            state_nxt    = RUN;
          end
        end
      end
      RUN: begin
        acc_hi_nxt = step_hi;
        acc_lo_nxt = step_lo | WIDTH'(step_qbit);
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        if (is_div) begin
          hi_nxt       = rem_fix;
          lo_nxt       = quo_fix;
          div_zero_nxt = dz;
        end else begin
          hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
          lo_nxt = prod_fix[WIDTH-1:0];
        end
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc_hi   <= acc_hi_nxt;
      acc_lo   <= acc_lo_nxt;
      opnd     <= opnd_nxt;
      is_div   <= is_div_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      dz       <= dz_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance side by side.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  int   tests;
  int   failed;

  logic        reset32, start32, busy32, done32, dz32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        reset8, start8, busy8, done8, dz8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset32), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, then count sampled cycles until done (bounded)
  task automatic run32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1; bcnt = 0;
    while (!done32 && lat < 100) begin
      if (busy32) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;
    tests = 0; failed = 0;
    reset32 = 1'b1; start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    reset8  = 1'b1; start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi",   64'(hi32), 64'h0);
    check("rst_lo",   64'(lo32), 64'h0);
    check("rst_busy", 64'(busy32), 64'h0);
    check("rst_done", 64'(done32), 64'h0);
    check("rst_dz",   64'(dz32), 64'h0);
    @(negedge clk);
    reset32 = 1'b0; reset8 = 1'b0;

    // MULTU max * max
    run32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    check("multu_lat",  64'(lat), 64'd34);
    check("multu_busy", 64'(bcnt), 64'd33);
    check("multu_hi",   64'(hi32), 64'hFFFFFFFE);
    check("multu_lo",   64'(lo32), 64'h00000001);
    check("multu_done_busy", 64'(busy32), 64'h0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done32), 64'h0);

    // MULT -3 * 5
    run32(OP_MULT, 32'hFFFFFFFD, 32'd5, lat, bcnt);
    check("mult_hi", 64'(hi32), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo32), 64'hFFFFFFF1);

    // DIV -7 / 2
    run32(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    check("div_lo", 64'(lo32), 64'hFFFFFFFD);
    check("div_hi", 64'(hi32), 64'hFFFFFFFF);
    check("div_dz", 64'(dz32), 64'h0);

    // DIVU by zero, then MULTU clears the flag
    run32(OP_DIVU, 32'h00001234, 32'd0, lat, bcnt);
    check("dz_hi", 64'(hi32), 64'h00001234);
    check("dz_lo", 64'(lo32), 64'hFFFFFFFF);
    check("dz_flag", 64'(dz32), 64'h1);
    run32(OP_MULTU, 32'd3, 32'd4, lat, bcnt);
    check("dz_clear", 64'(dz32), 64'h0);
    check("multu2_lo", 64'(lo32), 64'd12);
    check("multu2_hi", 64'(hi32), 64'd0);

    // Signed DIV by zero: HI keeps raw negative dividend
    run32(OP_DIV, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    check("sdz_hi", 64'(hi32), 64'hFFFFFFF9);
    check("sdz_lo", 64'(lo32), 64'hFFFFFFFF);
    check("sdz_flag", 64'(dz32), 64'h1);

    // Signed overflow MIN / -1
    run32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    check("ovf_lo", 64'(lo32), 64'h80000000);
    check("ovf_hi", 64'(hi32), 64'h0);

    // Restore known lo via MTLO, then MTHI with one-cycle latency
    @(negedge clk);
    op32 = OP_MTLO; a32 = 32'd12; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mtlo_lo", 64'(lo32), 64'd12);
    @(negedge clk);
    op32 = OP_MTHI; a32 = 32'hA5A5A5A5; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mthi_hi", 64'(hi32), 64'hA5A5A5A5);
    check("mthi_busy", 64'(busy32), 64'h0);
    check("mthi_done", 64'(done32), 64'h0);

    // DIV 100/7 with MTLO and DIV issued while busy
    @(negedge clk);
    op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    op32 = OP_MTLO; a32 = 32'hDEADBEEF; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("busy_mtlo_lo", 64'(lo32), 64'd12);
    check("busy_hi", 64'(hi32), 64'hA5A5A5A5);
    @(negedge clk);
    op32 = OP_DIV; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("busy_still", 64'(busy32), 64'h1);
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_div_lo", 64'(lo32), 64'd14);
    check("busy_div_hi", 64'(hi32), 64'd2);
    @(posedge clk); #1;
    check("second_div_ignored", 64'(busy32), 64'h0);

    // Illegal op leaves everything alone
    @(negedge clk);
    op32 = 5'b00000; a32 = 32'h11111111; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("illegal_busy", 64'(busy32), 64'h0);
    check("illegal_hi", 64'(hi32), 64'd2);
    check("illegal_lo", 64'(lo32), 64'd14);

    // Reset 10 cycles into a DIV aborts with no done
    @(negedge clk);
    op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset32 = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy32), 64'h0);
    check("abort_hi", 64'(hi32), 64'h0);
    check("abort_lo", 64'(lo32), 64'h0);
    @(negedge clk);
    reset32 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    // WIDTH=8 instance
    run8(OP_MULT, 8'h80, 8'h80, lat);
    check("w8_mult_lat", 64'(lat), 64'd10);
    check("w8_mult_hi", 64'(hi8), 64'h40);
    check("w8_mult_lo", 64'(lo8), 64'h00);
    run8(OP_DIV, 8'h80, 8'hFF, lat);
    check("w8_div_lo", 64'(lo8), 64'h80);
    check("w8_div_hi", 64'(hi8), 64'h00);
    check("w8_div_dz", 64'(dz8), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit owning the HI/LO register pair of the multicycle MIPS core. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO commands from the ALU control path. Multiply and divide run as a radix-2 FSM over WIDTH cycles. HI/LO stay readable at all times for MFHI/MFLO. The core stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/HI/LO width; legal range ≥ 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  command valid; sampled only in IDLE.
- `op`  in  5  ALU control code: 00111 MULTU, 01000 MULT, 01111 DIV, 10000 DIVU, 10001 MTHI, 10010 MTLO; others ignored.
- `a`  in  WIDTH  rs operand (multiplicand / dividend / MT* source).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `busy`  out  1  high while a multiply/divide is in flight.
- `done`  out  1  one-cycle pulse when HI/LO first show a new mul/div result.
- `div_zero`  out  1  sticky for the last DIV/DIVU; set if divisor was 0, cleared by the next accepted mul/div.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- Reset: state IDLE; `hi`, `lo`, `busy`, `done`, `div_zero` are all 0; internal accumulators are cleared.
- IDLE + `start` + MTHI/MTLO: the value of `a` goes to `hi` or `lo` at the same edge. No busy, no done.
- IDLE + `start` + mul/div: latch the operand magnitudes (absolute values for signed ops) and the result sign flags, then go to RUN with a counter of WIDTH.
- RUN, multiply: shift-add one bit per cycle into a 2·WIDTH product register.
- RUN, divide: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits.
- RUN → FIX when the counter reaches 0.
- FIX: apply the sign correction.
  - Multiply: negate the 2·WIDTH product if the operand signs differ.
  - Divide: the quotient takes sign a⊕b; the remainder takes the sign of `a`.
  - Write HI/LO as product[2W-1:W]/product[W-1:0] for multiply, or remainder/quotient for divide.
- FIX → IDLE.
- Divide by zero, both DIV and DIVU: HI = `a` unmodified, LO = all ones, `div_zero` = 1. No sign correction is applied.
- Signed overflow (MIN / −1): LO = MIN, HI = 0, following wrap-around two's-complement.
- `start` while busy: ignored entirely, including MT*. The core must hold the command until `busy` is low.
- `hi`/`lo` hold their old values throughout RUN/FIX and change only at the FIX→IDLE edge.
- Illegal `op` with `start`: no state change.

## Timing
- `start` is sampled at edge k.
- `busy` is 1 for cycles k+1 … k+WIDTH+1, covering WIDTH RUN cycles plus 1 FIX cycle.
- At cycle k+WIDTH+2 the new `hi`/`lo` are visible, `done` = 1, and `busy` = 0. A new `start` is accepted on that same cycle.
- Start-to-result latency is WIDTH+2 cycles; with WIDTH=32, `done` comes 34 cycles after `start`.
- MTHI/MTLO latency is 1 cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- `reset` mid-operation aborts the operation at the next edge, with all outputs returning to their reset values and no `done`.

## Structure
- Package `muldiv_pkg`:
  - op code localparams (shared with the ALU decoder codes above);
  - state enum {IDLE, RUN, FIX};
  - counter width `$clog2(WIDTH+1)`.
- Sub-module `muldiv_step`: purely combinational single iteration. It takes mode, accumulator and operand, and returns the next accumulator/quotient bit, for both the shift-add and the restoring-subtract step.
- The top level holds the FSM, counter, sign latches, HI/LO and `div_zero`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at start+34, HI=0xFFFFFFFE, LO=0x00000001, `busy` high for 33 cycles.
- MULT a=−3 (0xFFFFFFFD), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → HI=0x00001234, LO=0xFFFFFFFF, `div_zero`=1. A following MULTU clears `div_zero`.
- MTHI 0xA5A5A5A5 from IDLE → `hi` updates the next cycle. Then start DIV, issue MTLO and a second DIV during `busy` → both ignored. `hi`/`lo` stay unchanged until `done`.
- `reset` asserted 10 cycles into a DIV → next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse ever.
- WIDTH=8 build: MULT a=0x80, b=0x80 → HI=0x40, LO=0x00, `done` at start+10. DIV a=0x80, b=0xFF → LO=0x80, HI=0x00.
